// File: rtl/mp_add_pkg.sv
// Shared constants and state encoding for the multi-precision sequential adder.
package mp_add_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mp_add_seq_cla16.sv
// 16-bit carry-select adder: low half ripples, high half is precomputed for
// both carry values and selected by the low-half carry-out. Purely combinational.
module CLA_16
  import mp_add_pkg::*;
(
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic              Cin,
  output logic [WORD_W-1:0] Sum,
  output logic              Cout
);

  localparam int unsigned H = WORD_W / 2;

  logic [H:0] w_lo;
  logic [H:0] w_hi0;
  logic [H:0] w_hi1;

  assign w_lo  = {1'b0, A[H-1:0]} + {1'b0, B[H-1:0]} + {{H{1'b0}}, Cin};
  assign w_hi0 = {1'b0, A[WORD_W-1:H]} + {1'b0, B[WORD_W-1:H]};
  assign w_hi1 = {1'b0, A[WORD_W-1:H]} + {1'b0, B[WORD_W-1:H]} + {{H{1'b0}}, 1'b1};

  assign Sum[H-1:0]        = w_lo[H-1:0];
  assign {Cout, Sum[WORD_W-1:H]} = w_lo[H] ? w_hi1 : w_hi0;

endmodule

// File: rtl/mp_add_seq.sv
// Sequential multi-precision adder: feeds one 16-bit word per cycle (LSW first)
// through CLA_16, chaining the carry, and collects the result with valid/ready handshakes.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int unsigned NWORDS = 4,
  parameter int unsigned IDXW   = 2
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W*NWORDS-1:0]   a,
  input  logic [WORD_W*NWORDS-1:0]   b,
  input  logic                       cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W*NWORDS-1:0]   sum,
  output logic                       cout,
  output logic                       ovf
);

  localparam int unsigned W = WORD_W * NWORDS;

  state_t            r_state;
  state_t            w_next;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_sum;
  logic              r_carry;
  logic              r_cout;
  logic              r_ovf;
  logic              r_amsb;
  logic              r_bmsb;
  logic [IDXW-1:0]   r_cnt;

  logic [WORD_W-1:0] w_word_sum;
  logic              w_word_cout;
  logic              w_accept;
  logic              w_run;
  logic              w_last;

  CLA_16 u_cla (
    .A    (r_a[WORD_W-1:0]),
    .B    (r_b[WORD_W-1:0]),
    .Cin  (r_carry),
    .Sum  (w_word_sum),
    .Cout (w_word_cout)
  );

  assign w_last = (r_cnt == IDXW'(NWORDS - 1));

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    w_run     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_amsb  <= a[W-1];
        r_bmsb  <= b[W-1];
        r_cnt   <= '0;
      end else if (w_run) begin
        // Each word enters the result from the top, so the LSW ends at sum[15:0].
        r_sum   <= {w_word_sum, r_sum[W-1:WORD_W]};
        r_a     <= {{WORD_W{1'b0}}, r_a[W-1:WORD_W]};
        r_b     <= {{WORD_W{1'b0}}, r_b[W-1:WORD_W]};
        r_carry <= w_word_cout;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_cout <= w_word_cout;
          r_ovf  <= r_amsb ^ r_bmsb ^ w_word_sum[WORD_W-1] ^ w_word_cout;
        end
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed and random self-checking bench for mp_add_seq with NWORDS=4.
module tb_mp_add_seq;

  localparam int NWORDS = 4;
  localparam int W      = 16 * NWORDS;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_hs     = 0;

  mp_add_seq #(.NWORDS(NWORDS), .IDXW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready)   n_acc <= n_acc + 1;
    if (!rst && out_valid && out_ready) n_hs  <= n_hs + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, wait for result, optional stall, release.
  task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic tc,
                       input int stall, input bit chk_lat);
    logic [64:0] full;
    logic [63:0] es;
    logic        ec;
    logic        eo;
    int          lat;
    full = {1'b0, ta} + {1'b0, tb_v} + {64'd0, tc};
    es   = full[63:0];
    ec   = full[64];
    eo   = ta[63] ^ tb_v[63] ^ es[63] ^ ec;

    check("in_ready_before", 64'(in_ready), 64'd1);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = {$urandom(), $urandom()};
    b = {$urandom(), $urandom()};
    cin = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("in_ready_run", 64'(in_ready), 64'd0);
      tick();
      lat++;
    end
    check("out_valid_seen", 64'(out_valid), 64'd1);
    if (chk_lat) check("latency", 64'(lat), 64'd4);
    check("sum", sum, es);
    check("cout", 64'(cout), 64'(ec));
    check("ovf", 64'(ovf), 64'(eo));
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      tick();
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_sum", sum, es);
    end
    in_valid  = 1'($urandom_range(0, 1));
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("release_idle", 64'(in_ready), 64'd1);
    check("release_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int acc0, hs0;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // carry ripple through every word
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0, 1'b1);
    check("ripple_sum", sum, 64'd0);
    check("ripple_cout", 64'(cout), 64'd1);
    do_op(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 0, 1'b1);
    check("word_carry_sum", sum, 64'h0000_0000_0001_0000);
    // signed overflow
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b1);
    check("ovf_sum", sum, 64'h8000_0000_0000_0000);
    check("ovf_flag", 64'(ovf), 64'd1);
    check("ovf_cout", 64'(cout), 64'd0);
    // negative + negative without overflow, with carry out
    do_op(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0, 1'b1);
    check("negneg_sum", sum, 64'hFFFF_FFFF_FFFF_FFFB);
    check("negneg_ovf", 64'(ovf), 64'd0);
    // backpressure for 10 cycles
    acc0 = n_acc;
    do_op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0, 10, 1'b1);
    check("bp_sum", sum, 64'h0011_0022_0033_0044);
    check("bp_accepts", 64'(n_acc - acc0), 64'd1);

    // reset on the second RUN cycle
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_sum", sum, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    do_op(64'd5, 64'd7, 1'b0, 0, 1'b1);
    check("after_abort_sum", sum, 64'd12);

    // random regression with random stalls
    acc0 = n_acc;
    hs0  = n_hs;
    for (int i = 0; i < 1000; i++) begin
      do_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'b1);
    end
    check("rand_accepts", 64'(n_acc - acc0), 64'd1000);
    check("rand_handshakes", 64'(n_hs - hs0), 64'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
